// File: rtl/instruction_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: instruction format, class/opcode codes,
// controller states and the decoded-instruction record.
package instruction_dispatcher_pkg;

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [1:0] CLS_MEM     = 2'b10;
  localparam logic [1:0] CLS_CTRL    = 2'b11;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_JMP  = 4'd1;

  localparam int OPC_HI = 31, OPC_LO = 28;
  localparam int CLS_HI = 27, CLS_LO = 26;
  localparam int P1_HI  = 25, P1_LO  = 20;
  localparam int P2_HI  = 19, P2_LO  = 14;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LATCH, ST_DISPATCH, ST_WAIT, ST_ADVANCE, ST_HALTED, ST_ERROR
  } state_t;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [1:0]  cls;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [15:0] imm;
  } decode_t;

  // p2 and imm overlap on bits 15:14; both views are kept.
  function automatic decode_t decode(input logic [31:0] w);
    decode_t d;
    d.opcode = w[OPC_HI:OPC_LO];
    d.cls    = w[CLS_HI:CLS_LO];
    d.p1     = w[P1_HI:P1_LO];
    d.p2     = w[P2_HI:P2_LO];
    d.imm    = w[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// Stall watchdog: counts enabled cycles from a clear; expired flags the last allowed cycle.
module dispatch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/instruction_dispatcher.sv
// Fetch/decode/dispatch controller: launches one execution FSM per instruction and waits for its
// done pulse; JMP/HALT/NOP are handled here, and a watchdog catches FSMs that never finish.
module instruction_dispatcher
  import instruction_dispatcher_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] instr_addr,
  input  logic [31:0]     instr_data,
  output logic [3:0]      opcode,
  output logic [5:0]      param1,
  output logic [5:0]      param2,
  output logic [15:0]     immediate,
  output logic            start_alu_reg,
  output logic            start_alu_imm,
  output logic            start_mem,
  input  logic            done_alu_reg,
  input  logic            done_alu_imm,
  input  logic            done_mem,
  output logic            halted,
  output logic            error,
  output logic [15:0]     retired
);
  state_t          state, next_state;
  logic [PC_W-1:0] pc;
  decode_t         dec;
  logic            done_sel, wd_expired, in_wait, is_jmp;
  logic [1:0]      fetched_cls;

  assign instr_addr  = pc;
  assign opcode      = dec.opcode;
  assign param1      = dec.p1;
  assign param2      = dec.p2;
  assign immediate   = dec.imm;
  assign in_wait     = (state == ST_WAIT);
  assign is_jmp      = (dec.cls == CLS_CTRL) && (dec.opcode == OP_JMP);
  assign fetched_cls = instr_data[CLS_HI:CLS_LO];

  dispatch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wd_expired)
  );

  // Only the launched FSM's done is honoured.
  always_comb begin
    done_sel = 1'b0;
    case (dec.cls)
      CLS_ALU_REG: done_sel = done_alu_reg;
      CLS_ALU_IMM: done_sel = done_alu_imm;
      CLS_MEM:     done_sel = done_mem;
      default:     done_sel = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (run) next_state = ST_FETCH;
      ST_FETCH:    next_state = ST_LATCH;
      ST_LATCH:    next_state = ST_DISPATCH;
      ST_DISPATCH: begin
        if (dec.cls != CLS_CTRL)        next_state = ST_WAIT;
        else if (dec.opcode == OP_HALT) next_state = ST_HALTED;
        else                            next_state = ST_ADVANCE;
      end
      ST_WAIT: begin
        if (done_sel)        next_state = ST_ADVANCE;
        else if (wd_expired) next_state = ST_ERROR;
      end
      ST_ADVANCE:  next_state = run ? ST_FETCH : ST_IDLE;
      default:     next_state = state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      pc            <= '0;
      dec           <= '0;
      start_alu_reg <= 1'b0;
      start_alu_imm <= 1'b0;
      start_mem     <= 1'b0;
      halted        <= 1'b0;
      error         <= 1'b0;
      retired       <= '0;
    end else begin
      state <= next_state;
      // Pulses are decoded straight from ROM data so they line up with the DISPATCH cycle.
      start_alu_reg <= (state == ST_LATCH) && (fetched_cls == CLS_ALU_REG);
      start_alu_imm <= (state == ST_LATCH) && (fetched_cls == CLS_ALU_IMM);
      start_mem     <= (state == ST_LATCH) && (fetched_cls == CLS_MEM);
      halted        <= (next_state == ST_HALTED);
      error         <= (next_state == ST_ERROR);
      if (state == ST_LATCH) dec <= decode(instr_data);
      if (state == ST_ADVANCE) begin
        pc      <= is_jmp ? dec.imm[PC_W-1:0] : pc + 1'b1;
        retired <= retired + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_dispatcher.sv
// Bench for instruction_dispatcher: ROM model, execution-FSM model and a start-pulse scoreboard.
module tb_instruction_dispatcher;
  localparam int PC_W = 8;
  localparam int TO   = 20;

  logic            clock = 1'b0;
  logic            reset, run;
  logic [PC_W-1:0] instr_addr;
  logic [31:0]     instr_data;
  logic [3:0]      opcode;
  logic [5:0]      param1, param2;
  logic [15:0]     immediate, retired;
  logic            start_alu_reg, start_alu_imm, start_mem;
  logic            done_alu_reg = 1'b0, done_alu_imm = 1'b0, done_mem = 1'b0;
  logic            halted, error;

  instruction_dispatcher #(.PC_W(PC_W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .run(run),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .opcode(opcode), .param1(param1), .param2(param2), .immediate(immediate),
    .start_alu_reg(start_alu_reg), .start_alu_imm(start_alu_imm), .start_mem(start_mem),
    .done_alu_reg(done_alu_reg), .done_alu_imm(done_alu_imm), .done_mem(done_mem),
    .halted(halted), .error(error), .retired(retired)
  );

  always #5 clock = ~clock;

  logic [31:0] rom [256];
  always @(posedge clock) instr_data <= rom[instr_addr];

  typedef struct {
    logic [2:0]  starts;   // {mem, alu_imm, alu_reg}
    logic [3:0]  op;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [15:0] imm;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0, total_cnt = 0;
  int   start_cnt = 0;
  int   lat_cfg = 4, spur_at = 0;
  bit   no_done = 0;

  localparam logic [31:0] W_ALU_IMM = 32'h345000AA; // op3 cls01 p1=5 p2=0 imm=00AA
  localparam logic [31:0] W_ALU_REG = 32'h20108003; // op2 cls00 p1=1 p2=2 imm=8003
  localparam logic [31:0] W_MEM     = 32'h58700040; // op5 cls10 p1=7 p2=0 imm=0040
  localparam logic [31:0] W_HALT    = 32'h0C000000;
  localparam logic [31:0] W_JMP10   = 32'h1C000010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 256; i++) rom[i] = W_HALT;
    rom[0] = w0;
    rom[1] = w1;
  endtask

  task automatic wait_start(input int budget);
    int s0 = start_cnt;
    int i = 0;
    while (start_cnt == s0 && i < budget) begin step(1); i++; end
    chk("start_seen", 32'(start_cnt != s0), 32'd1);
  endtask

  task automatic wait_halted(input int budget);
    int i = 0;
    while (!halted && i < budget) begin step(1); i++; end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  // Scoreboard monitor: every start pulse must match the next expected dispatch.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b0 && (start_alu_reg | start_alu_imm | start_mem) === 1'b1) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_start: got %b, expected none",
                   {start_mem, start_alu_imm, start_alu_reg});
        end else begin
          e = sb.pop_front();
          chk("start_vec", 32'({start_mem, start_alu_imm, start_alu_reg}), 32'(e.starts));
          chk("start_op",  32'(opcode),    32'(e.op));
          chk("start_p1",  32'(param1),    32'(e.p1));
          chk("start_p2",  32'(param2),    32'(e.p2));
          chk("start_imm", 32'(immediate), 32'(e.imm));
        end
      end
    end
  end

  // Execution FSM model: done lat_cfg cycles after start; decode outputs must be unchanged then.
  initial begin
    bit          busy = 0;
    int          k = 0;
    logic [2:0]  which = '0;
    logic [3:0]  h_op = '0;
    logic [5:0]  h_p1 = '0, h_p2 = '0;
    logic [15:0] h_imm = '0;
    forever begin
      @(negedge clock);
      done_alu_reg = 1'b0; done_alu_imm = 1'b0; done_mem = 1'b0;
      if (reset !== 1'b0) busy = 0;
      else if ((start_alu_reg | start_alu_imm | start_mem) === 1'b1) begin
        busy = 1; k = 0; start_cnt++;
        which = {start_mem, start_alu_imm, start_alu_reg};
        h_op = opcode; h_p1 = param1; h_p2 = param2; h_imm = immediate;
      end else if (busy) begin
        k++;
        if (spur_at != 0 && k == spur_at && !which[2]) done_mem = 1'b1;
        if (!no_done && k == lat_cfg) begin
          if (which[0]) done_alu_reg = 1'b1;
          if (which[1]) done_alu_imm = 1'b1;
          if (which[2]) done_mem = 1'b1;
          chk("held_op",  32'(opcode),    32'(h_op));
          chk("held_p1",  32'(param1),    32'(h_p1));
          chk("held_p2",  32'(param2),    32'(h_p2));
          chk("held_imm", 32'(immediate), 32'(h_imm));
          busy = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    load(W_HALT, W_HALT);
    do_reset();
    chk("rst_addr", 32'(instr_addr), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_param1", 32'(param1), 0);
    chk("rst_param2", 32'(param2), 0);
    chk("rst_imm", 32'(immediate), 0);
    chk("rst_starts", 32'({start_mem, start_alu_imm, start_alu_reg}), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_retired", 32'(retired), 0);

    // ALU-imm, 11-cycle FSM; run dropped during WAIT pauses before the HALT.
    load(W_ALU_IMM, W_HALT);
    lat_cfg = 11;
    sb.push_back('{3'b010, 4'd3, 6'd5, 6'd0, 16'h00AA});
    run = 1'b1;
    wait_start(20);
    step(1); run = 1'b0;
    step(11);
    chk("imm_not_retired_yet", 32'(retired), 0);
    step(1);
    chk("imm_retired", 32'(retired), 1);
    chk("imm_pc", 32'(instr_addr), 1);
    step(5);
    chk("paused_not_halted", 32'(halted), 0);
    chk("paused_pc", 32'(instr_addr), 1);
    run = 1'b1;
    wait_halted(20);
    chk("imm_final_retired", 32'(retired), 1);

    // reg-reg, mem, HALT.
    do_reset();
    load(W_ALU_REG, W_MEM);
    rom[2] = W_HALT;
    lat_cfg = 4;
    s0 = start_cnt;
    sb.push_back('{3'b001, 4'd2, 6'd1, 6'd2, 16'h8003});
    sb.push_back('{3'b100, 4'd5, 6'd7, 6'd0, 16'h0040});
    run = 1'b1;
    wait_halted(100);
    chk("prog_pc", 32'(instr_addr), 2);
    chk("prog_retired", 32'(retired), 2);
    chk("prog_starts", 32'(start_cnt - s0), 2);

    // JMP to 0x10.
    do_reset();
    load(W_JMP10, W_ALU_REG);
    s0 = start_cnt;
    run = 1'b1;
    wait_halted(50);
    chk("jmp_pc", 32'(instr_addr), 32'h10);
    chk("jmp_retired", 32'(retired), 1);
    chk("jmp_no_start", 32'(start_cnt - s0), 0);

    // Watchdog timeout.
    do_reset();
    load(W_ALU_REG, W_HALT);
    no_done = 1;
    sb.push_back('{3'b001, 4'd2, 6'd1, 6'd2, 16'h8003});
    run = 1'b1;
    wait_start(20);
    step(TO);
    chk("to_error_early", 32'(error), 0);
    step(1);
    chk("to_error", 32'(error), 1);
    run = 1'b0;
    step(10);
    chk("to_error_hold", 32'(error), 1);
    chk("to_retired", 32'(retired), 0);
    chk("to_halted", 32'(halted), 0);
    no_done = 0;

    // Spurious done_mem during an alu_imm WAIT is ignored.
    do_reset();
    load(W_ALU_IMM, W_HALT);
    lat_cfg = 8; spur_at = 3;
    sb.push_back('{3'b010, 4'd3, 6'd5, 6'd0, 16'h00AA});
    run = 1'b1;
    wait_start(20);
    step(6);
    chk("spur_ignored", 32'(retired), 0);
    wait_halted(30);
    chk("spur_retired", 32'(retired), 1);
    chk("spur_pc", 32'(instr_addr), 1);
    spur_at = 0;

    // Reset mid-WAIT, then restart from PC 0.
    do_reset();
    load(W_ALU_IMM, W_HALT);
    no_done = 1;
    sb.push_back('{3'b010, 4'd3, 6'd5, 6'd0, 16'h00AA});
    run = 1'b1;
    wait_start(20);
    step(5);
    reset = 1'b1; run = 1'b0;
    step(1);
    reset = 1'b0;
    chk("mid_rst_pc", 32'(instr_addr), 0);
    chk("mid_rst_opcode", 32'(opcode), 0);
    chk("mid_rst_p1", 32'(param1), 0);
    chk("mid_rst_imm", 32'(immediate), 0);
    s0 = start_cnt;
    step(5);
    chk("mid_rst_no_reissue", 32'(start_cnt - s0), 0);
    load(W_MEM, W_HALT);
    no_done = 0; lat_cfg = 3;
    sb.push_back('{3'b100, 4'd5, 6'd7, 6'd0, 16'h0040});
    run = 1'b1;
    wait_halted(40);
    chk("restart_pc", 32'(instr_addr), 1);
    chk("restart_retired", 32'(retired), 1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
